mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares port A of the unified memory between two requesters: requester 0 (core load/store unit) and requester 1 (program loader / debug host). Single-issue, pipelined: one access granted per cycle, its response returned exactly one cycle later, tagged back to the owner. Requester 1 may lock the port for bursts, bounded by a starvation timer. Sits between the core/loader and the memory's port A; port B (instruction fetch) is untouched.

## Interface
- LOCK_MAX_CYCLES, 16: maximum consecutive locked grants to requester 1 while requester 0 is waiting.
- clk  in  1  single clock, drives memory port A clock.
- reset  in  1  synchronous, active-high; also driven to memory port A reset.
- r0_valid / r1_valid  in  1  request present.
- r0_ready / r1_ready  out  1  request accepted this cycle (grant).
- r0_we / r1_we  in  4  byte write enables; 0 = read.
- r0_addr / r1_addr  in  32  byte address, word aligned.
- r0_wdata / r1_wdata  in  32  write data.
- r1_lock  in  1  hold grant for next access (sampled with an accepted r1 request).
- r0_resp_valid / r1_resp_valid  out  1  response for access accepted previous cycle.
- resp_rdata  out  32  read data (shared; qualified by resp_valid).
- mem_en  out  1, mem_we  out  4, mem_addr  out  32, mem_din  out  32  to memory port A.
- mem_dout  in  32  from memory port A.

## Operation
- Grant is combinational from valid inputs and registered state; at most one ready high per cycle; mem_en = r0_ready | r1_ready; mem_we/addr/din muxed from the granted requester, else zero.
- State machine: OPEN, LOCKED.
  - OPEN: arbitrate per Configuration. If r1 accepted with r1_lock=1 -> LOCKED, lock counter cleared.
  - LOCKED: only r1 may be granted; r0_ready=0. Accepted r1 with r1_lock=0 -> OPEN. Counter increments each cycle r0_valid=1; at LOCK_MAX_CYCLES -> OPEN with r0 forced highest priority for one arbitration.
  - LOCKED with r1_valid=0: stays LOCKED (no grant), counter still advances if r0 waits.
- Response tag register: owner id + valid, loaded on every grant (reads and writes). Writes acknowledge with resp_valid; resp_rdata then undefined.
- resp_rdata = mem_dout unregistered. Addresses 8000_0000/8000_0004 pass through unchanged; memory-mapped behaviour belongs to the memory.
- Requester must hold valid/we/addr/wdata stable until ready; arbiter never drops an accepted request.

## Timing
- Reset values: r0_ready=r1_ready=0, both resp_valid=0, resp_rdata follows mem_dout, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, state OPEN, RR pointer favours r0, counter 0.
- While reset high: no grants, no memory enable.
- Latency: grant in cycle N -> resp_valid to owner in N+1. Throughput one access/cycle, back-to-back to same or alternating requesters.
- Reset asserted in cycle N+1 of an in-flight access: resp_valid suppressed, access lost.
- Simultaneous valid, OPEN, no forced-priority: arbitration rule decides; loser's ready stays 0.
- Counter saturates at LOCK_MAX_CYCLES; 4-bit minimum width, $clog2(LOCK_MAX_CYCLES+1).

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on contention the requester not granted most recently wins; pointer updates on every grant.
- Undefined: fixed priority, r0 always beats r1 in OPEN. Lock and starvation timer behave identically in both builds.

## Structure
- Shared package hubris_mem_pkg: OUTPUT_BYTES_AVAI_ADDR (8000_0000), OUTPUT_BYTES_ADDR (8000_0004), requester id type, arbiter state enum.
- One sub-module: arb_grant2 (two-input grant with optional round-robin pointer and force-r0 input).

## Test plan
- Reset: hold reset 3 cycles with both valids high -> no ready, mem_en=0, both resp_valid=0.
- Single read: write 0xDEADBEEF to 0x40 via r0, then r0 read 0x40 -> r0_resp_valid next cycle, resp_rdata=0xDEADBEEF, r1_resp_valid=0.
- Contention: both valid every cycle for 6 cycles -> RR build grants r0,r1,r0,r1,r0,r1; fixed build grants r0 six times.
- Lock: r1 locked burst of 4 writes to 0x100..0x10C while r0 waits -> r0_ready=0 throughout, r0 granted cycle after r1 drops lock.
- Starvation: r1_lock held forever, r0_valid high, LOCK_MAX_CYCLES=16 -> r0 granted exactly after 16 waiting cycles.
- Reset mid-flight: r1 read granted cycle N, reset in N+1 -> r1_resp_valid stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port definitions: MMIO output addresses, requester ids, arbiter state encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
package hubris_mem_pkg;

    localparam logic [31:0] OUTPUT_BYTES_AVAI_ADDR = 32'h8000_0000;
    localparam logic [31:0] OUTPUT_BYTES_ADDR      = 32'h8000_0004;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_e;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Lock counter must hold LOCK_MAX_CYCLES itself; never narrower than 4 bits.
    function automatic int lock_cnt_width(input int max_cycles);
        int w;
        w = $clog2(max_cycles + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for the port-A arbiter: two request channels plus tagged responses.
// Latency: n/a (wiring only). Backpressure: ready is the grant; requesters hold until it rises.
interface mem_port_arbiter_if;
    import hubris_mem_pkg::*;

    logic  r0_valid;
    logic  r0_ready;
    be_t   r0_we;
    word_t r0_addr;
    word_t r0_wdata;
    logic  r0_resp_valid;

    logic  r1_valid;
    logic  r1_ready;
    be_t   r1_we;
    word_t r1_addr;
    word_t r1_wdata;
    logic  r1_lock;
    logic  r1_resp_valid;

    word_t resp_rdata;

    modport master (
        output r0_valid, r0_we, r0_addr, r0_wdata,
        output r1_valid, r1_we, r1_addr, r1_wdata, r1_lock,
        input  r0_ready, r1_ready, r0_resp_valid, r1_resp_valid, resp_rdata
    );

    modport slave (
        input  r0_valid, r0_we, r0_addr, r0_wdata,
        input  r1_valid, r1_we, r1_addr, r1_wdata, r1_lock,
        output r0_ready, r1_ready, r0_resp_valid, r1_resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_grant2.sv
// Two-input grant: fixed r0 priority or round-robin on last winner, with a force-r0 override.
// Latency: combinational grant, pointer updated on every grant. Backpressure: loser sees no grant.
module arb_grant2
    import hubris_mem_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0_i,
    input  logic req1_i,
    input  logic force0_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    req_id_e last_q, last_d;
    logic    favour1;

    always_comb begin
        favour1 = RR_EN && (last_q == REQ_CORE) && !force0_i;
        gnt0_o  = req0_i && !(req1_i && favour1);
        gnt1_o  = req1_i && !gnt0_o;
        last_d  = last_q;
        if (gnt0_o) begin
            last_d = REQ_CORE;
        end else if (gnt1_o) begin
            last_d = REQ_LOADER;
        end
    end

    // Reset to "loader granted last" so the first contended cycle goes to r0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_LOADER;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Port-A arbiter for core (r0) and loader/debug (r1) with r1 burst lock and starvation timer; MEM_ARB_RR_EN selects round-robin.
// Latency: combinational grant, tagged response one cycle later. Backpressure: ready=0 until granted; no accepted access is dropped.
module mem_port_arbiter
    import hubris_mem_pkg::*;
#(
    parameter int LOCK_MAX_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                mem_en,
    output be_t                 mem_we,
    output word_t               mem_addr,
    output word_t               mem_din,
    input  word_t               mem_dout
);

    localparam int               CNT_W     = lock_cnt_width(LOCK_MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LOCK_MAX_CYCLES);
    localparam logic [0:0]       ST_OPEN   = ARB_OPEN;
    localparam logic [0:0]       ST_LOCKED = ARB_LOCKED;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             force_q, force_d;
    logic             tag_vld_q, tag_vld_d;
    req_id_e          tag_id_q, tag_id_d;
    logic             req0, req1, gnt0, gnt1;

    assign req0 = bus.r0_valid && !reset && (state_q == ST_OPEN);
    assign req1 = bus.r1_valid && !reset;

    arb_grant2 #(.RR_EN(RR_EN)) u_grant (
        .clk      (clk),
        .reset    (reset),
        .req0_i   (req0),
        .req1_i   (req1),
        .force0_i (force_q),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1)
    );

    assign bus.r0_ready = gnt0;
    assign bus.r1_ready = gnt1;
    assign mem_en       = gnt0 || gnt1;

    always_comb begin
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt0) begin
            mem_we   = bus.r0_we;
            mem_addr = bus.r0_addr;
            mem_din  = bus.r0_wdata;
        end else if (gnt1) begin
            mem_we   = bus.r1_we;
            mem_addr = bus.r1_addr;
            mem_din  = bus.r1_wdata;
        end
    end

    // Response owner follows the grant by one cycle; reset kills anything in flight.
    assign tag_vld_d          = gnt0 || gnt1;
    assign tag_id_d           = gnt1 ? REQ_LOADER : REQ_CORE;
    assign bus.r0_resp_valid  = tag_vld_q && (tag_id_q == REQ_CORE) && !reset;
    assign bus.r1_resp_valid  = tag_vld_q && (tag_id_q == REQ_LOADER) && !reset;
    assign bus.resp_rdata     = mem_dout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        force_d = 1'b0;
        case (state_q)
            ST_OPEN: begin
                if (gnt1 && bus.r1_lock) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (bus.r0_valid && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Starvation wins over a lock renewal: r0 gets the very next arbitration.
                if (cnt_d == CNT_MAX) begin
                    state_d = ST_OPEN;
                    force_d = 1'b1;
                end else if (gnt1 && !bus.r1_lock) begin
                    state_d = ST_OPEN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_OPEN;
            cnt_q     <= '0;
            force_q   <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_id_q  <= REQ_CORE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            force_q   <= force_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus lock, starvation and reset-in-flight sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [31:0] mem_model [0:255];

    int n_vec = 0;
    int n_bad = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.LOCK_MAX_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous read-first memory behind port A.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= mem_model[mem_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_model[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        r0v;
        logic [3:0]  r0we;
        logic [31:0] r0a;
        logic [31:0] r0d;
        logic        r1v;
        logic [3:0]  r1we;
        logic [31:0] r1a;
        logic [31:0] r1d;
        logic        r1lk;
        logic        e0;
        logic        e1;
        logic        e0rv;
        logic        e1rv;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(
        input logic rst,
        input logic r0v, input logic [3:0] r0we, input logic [31:0] r0a, input logic [31:0] r0d,
        input logic r1v, input logic [3:0] r1we, input logic [31:0] r1a, input logic [31:0] r1d,
        input logic r1lk,
        input logic e0, input logic e1, input logic e0rv, input logic e1rv,
        input logic chk_rd, input logic [31:0] e_rd);
        vec_t v;
        v.rst = rst; v.r0v = r0v; v.r0we = r0we; v.r0a = r0a; v.r0d = r0d;
        v.r1v = r1v; v.r1we = r1we; v.r1a = r1a; v.r1d = r1d; v.r1lk = r1lk;
        v.e0 = e0; v.e1 = e1; v.e0rv = e0rv; v.e1rv = e1rv;
        v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset        = v.rst;
        bus.r0_valid = v.r0v;
        bus.r0_we    = v.r0we;
        bus.r0_addr  = v.r0a;
        bus.r0_wdata = v.r0d;
        bus.r1_valid = v.r1v;
        bus.r1_we    = v.r1we;
        bus.r1_addr  = v.r1a;
        bus.r1_wdata = v.r1d;
        bus.r1_lock  = v.r1lk;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        logic [3:0]  x_we;
        logic [31:0] x_addr, x_din;
        x_we = '0; x_addr = '0; x_din = '0;
        if (v.e0) begin
            x_we = v.r0we; x_addr = v.r0a; x_din = v.r0d;
        end else if (v.e1) begin
            x_we = v.r1we; x_addr = v.r1a; x_din = v.r1d;
        end
        check({tag, ".r0_ready"}, 32'(bus.r0_ready), 32'(v.e0));
        check({tag, ".r1_ready"}, 32'(bus.r1_ready), 32'(v.e1));
        check({tag, ".r0_resp_valid"}, 32'(bus.r0_resp_valid), 32'(v.e0rv));
        check({tag, ".r1_resp_valid"}, 32'(bus.r1_resp_valid), 32'(v.e1rv));
        check({tag, ".mem_en"}, 32'(mem_en), 32'(v.e0 | v.e1));
        check({tag, ".mem_we"}, 32'(mem_we), 32'(x_we));
        check({tag, ".mem_addr"}, mem_addr, x_addr);
        check({tag, ".mem_din"}, mem_din, x_din);
        if (v.chk_rd) check({tag, ".resp_rdata"}, bus.resp_rdata, v.e_rd);
    endtask

    task automatic step(input vec_t v, input string tag);
        apply(v);
        @(negedge clk);
        check_vec(v, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  waits;
        bit  granted;
        bit  rr;
        vec_t v;

        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        mem_dout = '0;
`ifdef MEM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        // Reset held with both valids high, then single accesses, then contention from a fresh reset.
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(1, 1, 4'h0, 32'h40, 0, 1, 4'h0, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 4'hF, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 4'h0, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 4'h0, 32'h40, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 4'hF, 32'h44, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'hDEADBEEF));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 4'h0, 32'h44, 0, 0, 0, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h12345678));
        vt.push_back(mk(0, 1, 4'h0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            logic g0, p0, p1;
            g0 = rr ? ((i % 2) == 0) : 1'b1;
            p0 = (i > 0) && (rr ? ((i % 2) == 1) : 1'b1);
            p1 = (i > 0) && !p0;
            vt.push_back(mk(0, 1, 4'h0, 32'h40, 0, 1, 4'h0, 32'h44, 0, 0, g0, !g0, p0, p1,
                            i > 0, p0 ? 32'hDEADBEEF : 32'h12345678));
        end
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, !rr, rr, 1,
                        rr ? 32'h12345678 : 32'hDEADBEEF));

        apply(vt[0]);
        for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("row%0d", i));

        // Locked burst of four writes while r0 waits; r0 wins the cycle after the lock drops.
        step(mk(0, 0, 0, 0, 0, 1, 4'hF, 32'h100, 32'hA0, 1, 0, 1, 0, 0, 0, 0), "lock0");
        step(mk(0, 1, 4'h0, 32'h100, 0, 1, 4'hF, 32'h104, 32'hA1, 1, 0, 1, 0, 1, 0, 0), "lock1");
        step(mk(0, 1, 4'h0, 32'h100, 0, 1, 4'hF, 32'h108, 32'hA2, 1, 0, 1, 0, 1, 0, 0), "lock2");
        step(mk(0, 1, 4'h0, 32'h100, 0, 1, 4'hF, 32'h10C, 32'hA3, 0, 0, 1, 0, 1, 0, 0), "lock3");
        step(mk(0, 1, 4'h0, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0), "lock4");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hA0), "lock5");

        // Lock held forever: r0 must be granted after exactly 16 waiting cycles.
        step(mk(0, 0, 0, 0, 0, 1, 4'h0, 32'h100, 0, 1, 0, 1, 0, 0, 0, 0), "starve0");
        waits   = 0;
        granted = 1'b0;
        v = mk(0, 1, 4'h0, 32'h104, 0, 1, 4'h0, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40 && !granted; i++) begin
            apply(v);
            @(negedge clk);
            if (bus.r0_ready) begin
                granted = 1'b1;
                check("starve.wait_cycles", 32'(waits), 32'd16);
                check("starve.r1_ready_at_force", 32'(bus.r1_ready), 32'd0);
                check("starve.mem_addr", mem_addr, 32'h104);
            end else begin
                waits++;
                check($sformatf("starve.r1_ready_c%0d", i), 32'(bus.r1_ready), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        if (!granted) check("starve.timeout_r0_granted", 32'd0, 32'd1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hA1), "starve_resp");

        // Reset in the cycle after an r1 grant discards its response.
        step(mk(0, 0, 0, 0, 0, 1, 4'h0, 32'h44, 0, 0, 0, 1, 0, 0, 0, 0), "midrst0");
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "midrst1");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "midrst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
